sodor_imem_responder: RTL

//  Instruction-memory responder for the Sodor 5-stage core's imem request port.

---
 rtl/sodor_imem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sodor_imem_responder.sv
// -----------------------------------------------------------------------------
// sodor_imem_responder
//
// Instruction-memory responder for the Sodor 5-stage core's imem request port.
// A small word-addressed program store, loaded through a write port, answers
// core fetches after a fixed LATENCY. A flush kills every in-flight fetch except
// one accepted on the same edge.
//
// Handshake: a fetch is accepted on any posedge where req_valid && req_ready.
// req_ready is low only while reset is high. There is no response backpressure.
// resp_valid is therefore a one-cycle pulse, and at most LATENCY fetches are
// in flight.
//
// Ports
//   clock       in   1       single clock, all logic on posedge
//   reset       in   1       synchronous, active-high
//   req_valid   in   1       core fetch request valid
//   req_ready   out  1       responder can accept a request this cycle
//   req_addr    in   32      byte address of the fetch
//   resp_valid  out  1       fetch data valid this cycle
//   resp_data   out  32      instruction word
//   resp_addr   out  32      byte address the response answers
//   flush       in   1       discard all in-flight fetches
//   prog_we     in   1       program-store write enable
//   prog_addr   in   ADDR_W  word index to write
//   prog_data   in   32      word to write
//   fault       out  1       sticky: misaligned / out-of-range fetch accepted
//   resp_count  out  16      responses delivered since reset (wraps)
//
// Debug: the pipeline occupancy is exposed through dbg_stage_valid.
// -----------------------------------------------------------------------------
module sodor_imem_responder #(
    parameter int          ADDR_W   = 4,
    parameter int          LATENCY  = 1,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    output logic                resp_valid,
    output logic [31:0]         resp_data,
    output logic [31:0]         resp_addr,
    input  logic                flush,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [31:0]         prog_data,
    output logic                fault,
    output logic [15:0]         resp_count,
    output logic [LATENCY-1:0]  dbg_stage_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("sodor_imem_responder: LATENCY must be in 1..4");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
        $error("sodor_imem_responder: ADDR_W must be in 1..29");
    end

    // The store keeps each word XORed with NOP_INST. Storage is never reset, so an
    // all-zero power-up image reads back as NOP_INST until a word is written.
    logic [31:0] store_q [DEPTH];

    logic              accept;
    logic              addr_bad;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;

    logic [LATENCY-1:0] stg_valid;
    logic [31:0]        stg_addr [LATENCY];
    logic [31:0]        stg_data [LATENCY];
    logic               fault_q;
    logic [15:0]        count_q;

    assign req_ready = !reset;
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[ADDR_W+1:2];
    assign addr_bad  = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

    // Sampled on the accept edge. A same-edge write therefore returns the old word.
    assign rd_word   = addr_bad ? NOP_INST : (store_q[word_idx] ^ NOP_INST);

    always_ff @(posedge clock) begin
        if (prog_we) begin
            store_q[prog_addr] <= prog_data ^ NOP_INST;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stg_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_addr[i] <= 32'h0;
                stg_data[i] <= NOP_INST;
            end
            fault_q <= 1'b0;
            count_q <= 16'h0;
        end else begin
            // Stage 0 always takes the new accept. It is the redirect target when
            // flush is high, so flush never kills it.
            stg_valid[0] <= accept;
            stg_addr[0]  <= req_addr;
            stg_data[0]  <= rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1] && !flush;
                stg_addr[i]  <= stg_addr[i-1];
                stg_data[i]  <= stg_data[i-1];
            end
            if (accept && addr_bad) begin
                fault_q <= 1'b1;
            end
            // Counts the response presented during the cycle that ends at this edge.
            if (stg_valid[LATENCY-1]) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign resp_valid      = stg_valid[LATENCY-1];
    assign resp_data       = stg_data[LATENCY-1];
    assign resp_addr       = stg_addr[LATENCY-1];
    assign fault           = fault_q;
    assign resp_count      = count_q;
    assign dbg_stage_valid = stg_valid;

endmodule
